// File: rtl/pipe_exe_div_if.sv
// ---------------------------------------------------------------------------
// pipe_exe_div_if
// Bundles the execute-stage divide request and the divider's results.
//   master (pipeline side): drives Ediv, Esign, Ea, Eb, cancel;
//                           reads stall, busy, done, quotient, remainder.
//   slave  (divider side) : the reverse direction.
// ---------------------------------------------------------------------------
interface pipe_exe_div_if #(
  parameter int WIDTH = 32
);
  logic             Ediv;       // divide instruction in execute (start request)
  logic             Esign;      // 1 = signed DIV, 0 = unsigned DIVU
  logic [WIDTH-1:0] Ea;         // dividend
  logic [WIDTH-1:0] Eb;         // divisor
  logic             cancel;     // execute-stage flush
  logic             stall;      // hold PC, IF/ID and D/E this cycle
  logic             busy;       // divider FSM not idle
  logic             done;       // results valid this cycle (one-cycle pulse)
  logic [WIDTH-1:0] quotient;   // result for LO
  logic [WIDTH-1:0] remainder;  // result for HI

  modport master (
    output Ediv, Esign, Ea, Eb, cancel,
    input  stall, busy, done, quotient, remainder
  );

  modport slave (
    input  Ediv, Esign, Ea, Eb, cancel,
    output stall, busy, done, quotient, remainder
  );
endinterface

// File: rtl/pipe_exe_div.sv
// ---------------------------------------------------------------------------
// pipe_exe_div
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// A request taken in IDLE runs WIDTH shift/subtract steps in CALC, applies
// sign correction (or the divide-by-zero result) in FIX, and pulses done in
// DONE. While a request waits or runs, stall holds the front of the pipe.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of pipe_exe_div_if
//          in : Ediv, Esign, Ea, Eb, cancel
//          out: stall, busy, done, quotient, remainder
// ---------------------------------------------------------------------------
module pipe_exe_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  pipe_exe_div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;       // partial remainder
  logic [WIDTH-1:0] dvd_q;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;       // divisor magnitude
  logic [WIDTH-1:0] ea_q;        // original dividend, returned as remainder on div0
  logic             neg_quo_q;   // quotient must be negated
  logic             neg_rem_q;   // remainder must be negated
  logic             div0_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             done_q;

  // Operand magnitudes. |0x80000000| stays 0x80000000 and is then treated
  // as unsigned by the WIDTH+1 compare below.
  logic             a_neg_d, b_neg_d;
  logic [WIDTH-1:0] a_abs_d, b_abs_d;

  always_comb begin
    a_neg_d = bus.Esign & bus.Ea[WIDTH-1];
    b_neg_d = bus.Esign & bus.Eb[WIDTH-1];
    a_abs_d = a_neg_d ? (~bus.Ea + 1'b1) : bus.Ea;
    b_abs_d = b_neg_d ? (~bus.Eb + 1'b1) : bus.Eb;
  end

  // One restoring step: shift {rem,dvd} left, trial-subtract the divisor.
  logic [WIDTH:0]   rem_sh_d;
  logic             take_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  always_comb begin
    rem_sh_d = {rem_q, dvd_q[WIDTH-1]};
    take_d   = (rem_sh_d >= {1'b0, dvs_q});
    // When the subtract is taken the difference is below the divisor, so
    // its upper bit is always zero and the low WIDTH bits are exact.
    rem_d    = take_d ? (rem_sh_d[WIDTH-1:0] - dvs_q) : rem_sh_d[WIDTH-1:0];
    dvd_d    = {dvd_q[WIDTH-2:0], take_d};
  end

  // Final result selection applied in FIX.
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rmd_fix_d;

  always_comb begin
    if (div0_q) begin
      quo_fix_d = '1;
      rmd_fix_d = ea_q;
    end else begin
      quo_fix_d = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
      rmd_fix_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      ea_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.cancel) begin
        // Flush wins over everything, including a start in IDLE.
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.Ediv) begin
              dvd_q     <= a_abs_d;
              dvs_q     <= b_abs_d;
              ea_q      <= bus.Ea;
              neg_quo_q <= bus.Esign & (bus.Ea[WIDTH-1] ^ bus.Eb[WIDTH-1]);
              neg_rem_q <= a_neg_d;
              div0_q    <= (bus.Eb == '0);
              rem_q     <= '0;
              cnt_q     <= '0;
              state_q   <= CALC;
            end
          end
          CALC: begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= FIX;
            end
          end
          FIX: begin
            quo_q   <= quo_fix_d;
            rmd_q   <= rmd_fix_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          DONE: begin
            // Ediv still high here belongs to the divide just finished.
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Stall is combinational so the divide is held in D/E from its first
  // cycle; it drops in DONE so the pipeline advances at that edge. It is
  // also forced low while reset is asserted so every output reads zero.
  assign bus.stall     = bus.Ediv & (state_q != DONE) & ~bus.cancel & ~rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;

endmodule
